// File: rtl/ofifo_flex.sv
// Per-column output FIFO: each column is written independently, and aligned
// full-width vectors are popped through a registered read port.
module ofifo_flex #(
    parameter int unsigned col    = 8,
    parameter int unsigned bw     = 16,
    parameter int unsigned depth  = 64,
    parameter int unsigned aw     = 6,
    parameter int unsigned af_lvl = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [col*bw-1:0] in,
    input  logic [col-1:0]    wr,
    input  logic              rd,
    input  logic              flush,
    input  logic              clr_err,
    output logic [col*bw-1:0] out,
    output logic              o_out_valid,
    output logic              o_valid,
    output logic              o_ready,
    output logic              o_full,
    output logic              o_almost_full,
    output logic [aw:0]       o_min_count,
    output logic              o_overflow,
    output logic              o_underflow
);

    localparam int unsigned CW = aw + 1;
    localparam logic [aw:0] DEPTH_C = CW'(depth);
    localparam logic [aw:0] AF_TH   = CW'(depth - af_lvl);

    logic [aw-1:0]     wr_ptr_q [col];
    logic [aw-1:0]     wr_ptr_d [col];
    logic [aw-1:0]     rd_ptr_q [col];
    logic [aw-1:0]     rd_ptr_d [col];
    logic [aw:0]       count_q  [col];
    logic [aw:0]       count_d  [col];
    logic [bw-1:0]     mem_q    [col][depth];

    logic [col*bw-1:0] out_q, out_d;
    logic              out_valid_q, out_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic              pop_c;
    logic [col-1:0]    wr_acc_c;
    logic [col-1:0]    wr_drop_c;

    // Status flags derive from the count registers only
    always_comb begin
        o_valid       = 1'b1;
        o_full        = 1'b0;
        o_almost_full = 1'b0;
        o_min_count   = count_q[0];
        for (int unsigned i = 0; i < col; i++) begin
            if (count_q[i] == '0)      o_valid       = 1'b0;
            if (count_q[i] == DEPTH_C) o_full        = 1'b1;
            if (count_q[i] >= AF_TH)   o_almost_full = 1'b1;
            if (count_q[i] < o_min_count) o_min_count = count_q[i];
        end
        o_ready = ~o_full;
    end

    // Next-state: a pop frees a full column's slot for a write on the same edge
    always_comb begin
        pop_c       = rd & o_valid & ~flush;
        out_d       = out_q;
        out_valid_d = pop_c;
        overflow_d  = overflow_q & ~clr_err;
        underflow_d = underflow_q & ~clr_err;
        wr_acc_c    = '0;
        wr_drop_c   = '0;
        for (int unsigned i = 0; i < col; i++) begin
            wr_acc_c[i]  = wr[i] & ~flush & ((count_q[i] != DEPTH_C) | pop_c);
            wr_drop_c[i] = wr[i] & ~flush & ~wr_acc_c[i];
            wr_ptr_d[i]  = wr_ptr_q[i] + aw'(wr_acc_c[i]);
            rd_ptr_d[i]  = rd_ptr_q[i] + aw'(pop_c);
            count_d[i]   = count_q[i];
            if (wr_acc_c[i] && !pop_c)      count_d[i] = count_q[i] + CW'(1);
            else if (!wr_acc_c[i] && pop_c) count_d[i] = count_q[i] - CW'(1);
            if (flush) begin
                wr_ptr_d[i] = '0;
                rd_ptr_d[i] = '0;
                count_d[i]  = '0;
            end
            if (pop_c) out_d[i*bw +: bw] = mem_q[i][rd_ptr_q[i]];
        end
        if (|wr_drop_c) overflow_d = 1'b1;
        if (rd && !o_valid && !flush) underflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < col; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < col; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                count_q[i]  <= count_d[i];
            end
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array carries no reset; contents are meaningless until written
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < col; i++) begin
            if (wr_acc_c[i]) mem_q[i][wr_ptr_q[i]] <= in[i*bw +: bw];
        end
    end

    assign out         = out_q;
    assign o_out_valid = out_valid_q;
    assign o_overflow  = overflow_q;
    assign o_underflow = underflow_q;

endmodule

// File: tb/tb_ofifo_flex.sv
// Directed bench for ofifo_flex: vector table for basic push/pop/underflow,
// then hand sequences for full/overflow, wrap, flush, sticky flags and reset.
module tb_ofifo_flex;

    localparam int unsigned COL = 8;
    localparam int unsigned BW  = 16;
    localparam int unsigned DW  = COL * BW;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] in;
    logic [7:0]    wr;
    logic          rd, flush, clr_err;
    logic [DW-1:0] out;
    logic          o_out_valid, o_valid, o_ready, o_full, o_almost_full;
    logic [6:0]    o_min_count;
    logic          o_overflow, o_underflow;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ofifo_flex #(.col(8), .bw(16), .depth(64), .aw(6), .af_lvl(4)) dut (
        .clk(clk), .reset(reset), .in(in), .wr(wr), .rd(rd), .flush(flush),
        .clr_err(clr_err), .out(out), .o_out_valid(o_out_valid),
        .o_valid(o_valid), .o_ready(o_ready), .o_full(o_full),
        .o_almost_full(o_almost_full), .o_min_count(o_min_count),
        .o_overflow(o_overflow), .o_underflow(o_underflow)
    );

    typedef struct {
        logic [7:0]    wr;
        logic          rd;
        logic          clr;
        logic [DW-1:0] e_out;
        logic          e_ov;
        logic          e_v;
        logic [6:0]    e_min;
        logic          e_unf;
    } vec_t;

    vec_t tv[16];

    function automatic logic [DW-1:0] pat(input int k);
        logic [DW-1:0] r;
        for (int i = 0; i < COL; i++) r[i*BW +: BW] = {8'(k), 8'(i)};
        return r;
    endfunction

    function automatic logic [DW-1:0] all16(input logic [15:0] v);
        logic [DW-1:0] r;
        for (int i = 0; i < COL; i++) r[i*BW +: BW] = v;
        return r;
    endfunction

    function automatic logic [DW-1:0] seqv(input int p);
        logic [DW-1:0] r;
        for (int i = 0; i < COL; i++) r[i*BW +: BW] = 16'(p * 8 + i);
        return r;
    endfunction

    task automatic chkv(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chkn(input string nm, input logic [6:0] act, input logic [6:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; in = '0; wr = '0; rd = 1'b0; flush = 1'b0; clr_err = 1'b0;

        tv[0]  = '{8'hFF, 1'b0, 1'b0, '0,      1'b0, 1'b1, 7'd1, 1'b0};
        tv[1]  = '{8'hFF, 1'b0, 1'b0, '0,      1'b0, 1'b1, 7'd2, 1'b0};
        tv[2]  = '{8'hFF, 1'b0, 1'b0, '0,      1'b0, 1'b1, 7'd3, 1'b0};
        tv[3]  = '{8'h00, 1'b1, 1'b0, pat(0),  1'b1, 1'b1, 7'd2, 1'b0};
        tv[4]  = '{8'h00, 1'b1, 1'b0, pat(1),  1'b1, 1'b1, 7'd1, 1'b0};
        tv[5]  = '{8'h00, 1'b1, 1'b0, pat(2),  1'b1, 1'b0, 7'd0, 1'b0};
        tv[6]  = '{8'h00, 1'b0, 1'b0, pat(2),  1'b0, 1'b0, 7'd0, 1'b0};
        tv[7]  = '{8'hFF, 1'b0, 1'b0, pat(2),  1'b0, 1'b1, 7'd1, 1'b0};
        tv[8]  = '{8'hFF, 1'b0, 1'b0, pat(2),  1'b0, 1'b1, 7'd2, 1'b0};
        tv[9]  = '{8'h01, 1'b0, 1'b0, pat(2),  1'b0, 1'b1, 7'd2, 1'b0};
        tv[10] = '{8'h01, 1'b0, 1'b0, pat(2),  1'b0, 1'b1, 7'd2, 1'b0};
        tv[11] = '{8'h01, 1'b0, 1'b0, pat(2),  1'b0, 1'b1, 7'd2, 1'b0};
        tv[12] = '{8'h00, 1'b1, 1'b0, pat(7),  1'b1, 1'b1, 7'd1, 1'b0};
        tv[13] = '{8'h00, 1'b1, 1'b0, pat(8),  1'b1, 1'b0, 7'd0, 1'b0};
        tv[14] = '{8'h00, 1'b1, 1'b0, pat(8),  1'b0, 1'b0, 7'd0, 1'b1};
        tv[15] = '{8'h00, 1'b0, 1'b1, pat(8),  1'b0, 1'b0, 7'd0, 1'b0};

        // Reset values while reset is held low
        #12;
        chkv("rst_out", out, '0);
        chkb("rst_out_valid", o_out_valid, 1'b0);
        chkb("rst_valid", o_valid, 1'b0);
        chkb("rst_ready", o_ready, 1'b1);
        chkb("rst_full", o_full, 1'b0);
        chkb("rst_af", o_almost_full, 1'b0);
        chkn("rst_min", o_min_count, 7'd0);
        chkb("rst_ovf", o_overflow, 1'b0);
        chkb("rst_unf", o_underflow, 1'b0);
        reset = 1'b1;

        // Basic push/pop, skewed columns, underflow and error clear
        for (int k = 0; k < 16; k++) begin
            wr = tv[k].wr; rd = tv[k].rd; clr_err = tv[k].clr; in = pat(k);
            step();
            chkv($sformatf("tv%0d_out", k), out, tv[k].e_out);
            chkb($sformatf("tv%0d_ov", k), o_out_valid, tv[k].e_ov);
            chkb($sformatf("tv%0d_valid", k), o_valid, tv[k].e_v);
            chkn($sformatf("tv%0d_min", k), o_min_count, tv[k].e_min);
            chkb($sformatf("tv%0d_unf", k), o_underflow, tv[k].e_unf);
            chkb($sformatf("tv%0d_ovf", k), o_overflow, 1'b0);
        end
        wr = '0; rd = 1'b0; clr_err = 1'b0;

        flush = 1'b1; step(); flush = 1'b0;
        chkn("flush0_min", o_min_count, 7'd0);
        chkb("flush0_valid", o_valid, 1'b0);

        // Fill column 3, overflow, then fill the rest
        for (int j = 0; j < 64; j++) begin
            in = all16(16'(j)); wr = 8'h08; step();
            if (j == 58) chkb("af_at59", o_almost_full, 1'b0);
            if (j == 59) chkb("af_at60", o_almost_full, 1'b1);
        end
        chkb("c3_full", o_full, 1'b1);
        chkb("c3_ready", o_ready, 1'b0);
        chkb("c3_ovf0", o_overflow, 1'b0);
        in = all16(16'hDEAD); wr = 8'h08; step();
        chkb("c3_ovf1", o_overflow, 1'b1);
        for (int j = 0; j < 64; j++) begin
            in = all16(16'(j)); wr = 8'hF7; step();
        end
        chkn("allfull_min", o_min_count, 7'd64);
        wr = '0; clr_err = 1'b1; step(); clr_err = 1'b0;
        chkb("clr_ovf", o_overflow, 1'b0);
        in = all16(16'hBEEF); wr = 8'hFF; rd = 1'b1; step();
        chkv("fullrw_out", out, all16(16'd0));
        chkb("fullrw_ov", o_out_valid, 1'b1);
        chkn("fullrw_min", o_min_count, 7'd64);
        chkb("fullrw_ovf", o_overflow, 1'b0);
        wr = '0;
        for (int j = 1; j <= 64; j++) begin
            rd = 1'b1; step();
            chkv($sformatf("drain%0d", j), out, (j < 64) ? all16(16'(j)) : all16(16'hBEEF));
        end
        rd = 1'b0;
        chkb("drain_valid", o_valid, 1'b0);
        chkn("drain_min", o_min_count, 7'd0);

        // Steady occupancy 10 with pointer wrap
        for (int p = 0; p < 10; p++) begin
            in = seqv(p); wr = 8'hFF; step();
        end
        chkn("pre_min", o_min_count, 7'd10);
        for (int p = 0; p < 200; p++) begin
            in = seqv(p + 10); wr = 8'hFF; rd = 1'b1; step();
            chkv($sformatf("wrap%0d", p), out, seqv(p));
        end
        rd = 1'b0;
        chkn("wrap_min", o_min_count, 7'd10);

        // Flush at occupancy 20 with a pop pending
        for (int p = 210; p < 220; p++) begin
            in = seqv(p); wr = 8'hFF; step();
        end
        chkn("occ20", o_min_count, 7'd20);
        in = seqv(220); wr = 8'hFF; rd = 1'b1; step();
        chkv("prefl_out", out, seqv(200));
        chkb("prefl_ov", o_out_valid, 1'b1);
        in = seqv(221); flush = 1'b1; step();
        flush = 1'b0; wr = '0; rd = 1'b0;
        chkv("fl_out", out, seqv(200));
        chkb("fl_ov", o_out_valid, 1'b0);
        chkn("fl_min", o_min_count, 7'd0);
        chkb("fl_valid", o_valid, 1'b0);
        chkb("fl_unf", o_underflow, 1'b0);

        // Sticky underflow: error on the clearing edge wins
        rd = 1'b1; step();
        chkb("unf_set", o_underflow, 1'b1);
        clr_err = 1'b1; step();
        chkb("unf_win", o_underflow, 1'b1);
        rd = 1'b0; step(); clr_err = 1'b0;
        chkb("unf_clr", o_underflow, 1'b0);

        // Async reset mid-burst
        for (int c = 0; c < 3; c++) begin
            in = pat(100 + c); wr = 8'hFF; step();
        end
        wr = '0; rd = 1'b1; step();
        rd = 1'b0;
        chkv("ar_pre_out", out, pat(100));
        #3 reset = 1'b0;
        #1;
        chkv("ar_out", out, '0);
        chkb("ar_ov", o_out_valid, 1'b0);
        chkb("ar_valid", o_valid, 1'b0);
        chkn("ar_min", o_min_count, 7'd0);
        chkb("ar_ready", o_ready, 1'b1);
        #1 reset = 1'b1;
        in = pat(50); wr = 8'hFF; step();
        in = pat(51); step();
        wr = '0; rd = 1'b1; step();
        chkv("post_out0", out, pat(50));
        step();
        chkv("post_out1", out, pat(51));
        chkb("post_ov", o_out_valid, 1'b1);
        rd = 1'b0;
        chkb("post_valid", o_valid, 1'b0);
        step();
        chkb("post_ov0", o_out_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
